// File: rtl/th99c_bus_interface.sv
`default_nettype none
// ============================================================================
// th99c_bus_interface : synchronised multiplexed-bus slave and config regfile
// Revision: 1.0
// ============================================================================
module th99c_bus_interface #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  B_RESET     = 8'd10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ABUS,
    inout  wire  [7:0]  DBUS,
    input  logic        CSbar,
    input  logic        ALE,
    input  logic        Rbar,
    input  logic        Wbar,
    output logic [55:0] b_all,
    output logic [7:0]  operand,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic        cfg_update,
    output logic [3:0]  cfg_addr
);

    localparam logic [7:0] ADDR_OPERAND = 8'd7;
    localparam logic [7:0] ADDR_HOUR    = 8'd8;
    localparam logic [7:0] ADDR_MINUTE  = 8'd9;
    localparam logic [7:0] ADDR_STATUS  = 8'd10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ARMED    = 3'd2,
        S_WRITE    = 3'd3,
        S_WAIT_REL = 3'd4,
        S_READ     = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0]      ale_sync_q, ale_sync_d;
    logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]      rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0]      wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0][7:0] abus_sync_q, abus_sync_d;
    logic [SYNC_STAGES-1:0][7:0] dbus_sync_q, dbus_sync_d;

    logic       ale_prev_q, ale_prev_d;
    logic       wbar_prev_q, wbar_prev_d;
    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [6:0][7:0] b_q, b_d;
    logic [7:0] operand_q, operand_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] minute_q, minute_d;
    logic [2:0] status_q, status_d;
    logic       cfg_update_q, cfg_update_d;
    logic [3:0] cfg_addr_q, cfg_addr_d;

    logic       ale_s, csbar_s, rbar_s, wbar_s;
    logic [7:0] abus_s, dbus_s;
    logic       ale_rise, ale_fall, wbar_fall;
    logic       store;
    logic [2:0] status_set;
    logic       status_clr;
    logic [7:0] rd_data;
    logic       dbus_oe;

    assign ale_s   = ale_sync_q[SYNC_STAGES-1];
    assign csbar_s = cs_sync_q[SYNC_STAGES-1];
    assign rbar_s  = rd_sync_q[SYNC_STAGES-1];
    assign wbar_s  = wr_sync_q[SYNC_STAGES-1];
    assign abus_s  = abus_sync_q[SYNC_STAGES-1];
    assign dbus_s  = dbus_sync_q[SYNC_STAGES-1];

    assign ale_rise  = ale_s & ~ale_prev_q;
    assign ale_fall  = ~ale_s & ale_prev_q;
    assign wbar_fall = ~wbar_s & wbar_prev_q;

    always_comb begin
        ale_sync_d  = {ale_sync_q[SYNC_STAGES-2:0], ALE};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CSbar};
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], Rbar};
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], Wbar};
        abus_sync_d = {abus_sync_q[SYNC_STAGES-2:0], ABUS};
        dbus_sync_d = {dbus_sync_q[SYNC_STAGES-2:0], DBUS};
        ale_prev_d  = ale_s;
        wbar_prev_d = wbar_s;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        b_d          = b_q;
        operand_d    = operand_q;
        hour_d       = hour_q;
        minute_d     = minute_q;
        cfg_update_d = 1'b0;
        cfg_addr_d   = cfg_addr_q;
        store        = 1'b0;
        status_set   = 3'b000;
        status_clr   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ale_rise) state_d = S_ADDR;
            end
            S_ADDR: begin
                addr_d = abus_s;
                if (ale_fall) state_d = S_ARMED;
            end
            S_ARMED: begin
                // Write is checked first so a simultaneous read never drives DBUS.
                if (ale_rise)                              state_d = S_ADDR;
                else if (wbar_fall && !csbar_s)            state_d = S_WRITE;
                else if (!rbar_s && !csbar_s && wbar_s)    state_d = S_READ;
            end
            S_WRITE: begin
                state_d = S_WAIT_REL;
                if (addr_q < ADDR_OPERAND) begin
                    for (int i = 0; i < 7; i++) begin
                        if (addr_q == 8'(i)) b_d[i] = dbus_s;
                    end
                    store = 1'b1;
                end else if (addr_q == ADDR_OPERAND) begin
                    operand_d = dbus_s;
                    store     = 1'b1;
                end else if (addr_q == ADDR_HOUR) begin
                    if (dbus_s <= 8'd23) begin
                        hour_d = dbus_s[4:0];
                        store  = 1'b1;
                    end else begin
                        status_set[0] = 1'b1;
                    end
                end else if (addr_q == ADDR_MINUTE) begin
                    if (dbus_s <= 8'd59) begin
                        minute_d = dbus_s[5:0];
                        store    = 1'b1;
                    end else begin
                        status_set[1] = 1'b1;
                    end
                end else begin
                    status_set[2] = 1'b1;
                end
                cfg_update_d = store;
                if (store) cfg_addr_d = addr_q[3:0];
            end
            S_WAIT_REL: begin
                if (wbar_s) state_d = S_IDLE;
            end
            S_READ: begin
                if (rbar_s) begin
                    state_d    = S_IDLE;
                    status_clr = (addr_q == ADDR_STATUS);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh error outranks a clear-on-read landing in the same cycle.
        status_d = (status_q & ~{3{status_clr}}) | status_set;
    end

    always_comb begin
        rd_data = 8'h00;
        if (addr_q < ADDR_OPERAND) begin
            for (int i = 0; i < 7; i++) begin
                if (addr_q == 8'(i)) rd_data = b_q[i];
            end
        end else if (addr_q == ADDR_OPERAND) begin
            rd_data = operand_q;
        end else if (addr_q == ADDR_HOUR) begin
            rd_data = {3'b000, hour_q};
        end else if (addr_q == ADDR_MINUTE) begin
            rd_data = {2'b00, minute_q};
        end else if (addr_q == ADDR_STATUS) begin
            rd_data = {5'b00000, status_q};
        end
    end

    // Released combinationally as soon as the synchronised Rbar returns high.
    assign dbus_oe = (state_q == S_READ) && !rbar_s;
    assign DBUS    = dbus_oe ? rd_data : {8{1'bz}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ale_sync_q   <= '0;
            cs_sync_q    <= '1;
            rd_sync_q    <= '1;
            wr_sync_q    <= '1;
            abus_sync_q  <= '0;
            dbus_sync_q  <= '0;
            ale_prev_q   <= 1'b0;
            wbar_prev_q  <= 1'b1;
            state_q      <= S_IDLE;
            addr_q       <= 8'h00;
            b_q          <= {7{B_RESET}};
            operand_q    <= 8'h00;
            hour_q       <= 5'd0;
            minute_q     <= 6'd0;
            status_q     <= 3'b000;
            cfg_update_q <= 1'b0;
            cfg_addr_q   <= 4'd0;
        end else begin
            ale_sync_q   <= ale_sync_d;
            cs_sync_q    <= cs_sync_d;
            rd_sync_q    <= rd_sync_d;
            wr_sync_q    <= wr_sync_d;
            abus_sync_q  <= abus_sync_d;
            dbus_sync_q  <= dbus_sync_d;
            ale_prev_q   <= ale_prev_d;
            wbar_prev_q  <= wbar_prev_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            b_q          <= b_d;
            operand_q    <= operand_d;
            hour_q       <= hour_d;
            minute_q     <= minute_d;
            status_q     <= status_d;
            cfg_update_q <= cfg_update_d;
            cfg_addr_q   <= cfg_addr_d;
        end
    end

    assign b_all      = b_q;
    assign operand    = operand_q;
    assign hour       = hour_q;
    assign minute     = minute_q;
    assign cfg_update = cfg_update_q;
    assign cfg_addr   = cfg_addr_q;

endmodule
`default_nettype wire

// File: doc/th99c_bus_interface.md
Name: th99c_bus_interface

Overview:
Microcontroller-side bus interface unit that sits directly upstream of the TH99CHLS display/time core. It synchronises the asynchronous multiplexed bus strobes (ALE, CSbar, Rbar, Wbar) into the clock domain and latches the address phase. It commits write data into the configuration register file (B0..B6, operand, hour, minute) and returns register contents on reads. The core consumes the register outputs and the one-cycle update pulse.

Parameters:
SYNC_STAGES, 2, flops per synchroniser on ALE/CSbar/Rbar/Wbar/ABUS/DBUS (allowed range 2..3)
B_RESET, 8'd10, reset value of B0..B6 (blank-digit code)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
ABUS  input  8  address bus; valid while ALE high
DBUS  inout  8  data bus; driven by this block only in READ state, else high-Z
CSbar  input  1  chip select, active low
ALE  input  1  address latch enable, active high
Rbar  input  1  read strobe, active low
Wbar  input  1  write strobe, active low
b_all  output  56  B0..B6 packed, B0 in [7:0], B6 in [55:48]
operand  output  8  operand register
hour  output  5  hour register, 0..23
minute  output  6  minute register, 0..59
cfg_update  output  1  one-cycle pulse when any register commits
cfg_addr  output  4  register index of the last commit; valid with cfg_update

Behaviour:
- Reset (reset=0, asynchronous): b_all = {7{B_RESET}}, operand=0, hour=0, minute=0, status=0, cfg_update=0, cfg_addr=0, DBUS high-Z, FSM=IDLE, synchronisers cleared to the inactive level (ALE=0, strobes=1).
- Address map: 0..6 B0..B6; 7 operand; 8 hour; 9 minute; 10 STATUS (read-only: bit0 hour_err, bit1 minute_err, bit2 map_err, bits 7:3 = 0); 11..255 unmapped.
- Synchronised signals are denoted *_s. Edges are detected on *_s versus the previous-cycle value.
- FSM:
  IDLE: ALE_s rise -> ADDR.
  ADDR: latch ABUS_s into addr_q every cycle. ALE_s fall -> ARMED.
  ARMED: ALE_s rise -> ADDR (transaction abandoned). Wbar_s fall & CSbar_s=0 -> WRITE. Rbar_s=0 & CSbar_s=0 -> READ. A strobe with CSbar_s=1 is ignored; FSM stays in ARMED.
  WRITE (1 cycle): commit DBUS_s to addr_q -> WAIT_REL.
  WAIT_REL: Wbar_s=1 -> IDLE.
  READ: DBUS driven with the value at addr_q. Rbar_s=1 -> IDLE, and DBUS goes high-Z in that same cycle. If STATUS was read, clear status on exit.
- Write rules, applied in WRITE:
  - addr 0..7: store as-is.
  - addr 8: value <=23 stores into hour; else hour unchanged and hour_err set.
  - addr 9: value <=59 stores into minute; else minute unchanged and minute_err set.
  - addr >=10: no store; map_err set.
- cfg_update pulses for exactly one cycle, the cycle after WRITE, and only when a store occurred. cfg_addr holds addr_q[3:0].
- Latency: register output changes at most SYNC_STAGES+2 clocks after Wbar goes low at the pins.
- Reads: unmapped addresses return 8'h00. A read of hour or minute is zero-extended.
- Bus timing contract:
  - ALE high for >= SYNC_STAGES+1 clocks.
  - Wbar/Rbar low for >= SYNC_STAGES+2 clocks.
  - DBUS stable throughout Wbar low.
- Simultaneous events:
  - Rbar_s and Wbar_s both low in ARMED: write wins; DBUS is not driven.
  - A status error and a STATUS read clear in the same cycle: the set wins.
- A reset asserted mid-write leaves the target register at its reset value. After reset release, no commit occurs until a fresh ALE phase.

Test Plan:
- Write 10 to addresses 0..6, 0xFF to 7, 23 to 8, 33 to 9 -> b_all={7{8'd10}}, operand=8'hFF, hour=23, minute=33; 10 cfg_update pulses with cfg_addr 0..9 in order.
- Write 24 to addr 8, then 60 to addr 9 -> hour and minute unchanged, no cfg_update; read addr 10 returns 8'h03; a second read of addr 10 returns 8'h00.
- Write 8'h5A to addr 3, then read addr 3 -> DBUS=8'h5A while Rbar low and high-Z within SYNC_STAGES+1 clocks after Rbar rises; read addr 200 returns 8'h00.
- Write 8'h77 to addr 0 with CSbar=1 -> B0 stays 10, no pulse. Write 8'h12 to addr 12 -> map_err set (STATUS=8'h04).
- Pulse reset low while Wbar is low during a write of 8'h44 to addr 5 -> B5=10. After release, a full ALE+Wbar cycle writing 8'h44 to addr 5 sets B5=8'h44.
- ALE phase to addr 1, then a new ALE phase to addr 2 before any strobe, then write 8'h09 -> B2=9, B1 unchanged.
